capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Arms on request, captures a triggered burst of I/Q samples
//               into an external buffer over a simple write bus, waits for
//               every write ack, then replays the buffer through a
//               valid/ready readout port.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic                       in_valid,
    input  logic signed [i_bits-1:0]   in_i,
    input  logic signed [q_bits-1:0]   in_q,
    input  logic                       start_read,
    output logic [index_bits-1:0]      m_axi_waddr,
    output logic                       m_axi_wvalid,
    output logic [i_bits+q_bits-1:0]   m_axi_wdata,
    input  logic                       s_axi_wready,
    input  logic                       s_axi_bvalid,
    output logic [index_bits-1:0]      m_axi_raddr,
    output logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    input  logic                       s_axi_rvalid,
    input  logic signed [i_bits-1:0]   s_i,
    input  logic signed [q_bits-1:0]   s_q,
    output logic signed [i_bits-1:0]   out_i,
    output logic signed [q_bits-1:0]   out_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       capture_done,
    output logic                       overflow,
    output logic                       busy
);

    // Counters carry one extra bit so they can hold buffer_length itself.
    localparam int              c_CW   = index_bits + 1;
    localparam logic [c_CW-1:0] c_LEN  = c_CW'(buffer_length);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(buffer_length - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ARMED     = 3'd1;
    localparam logic [2:0] c_CAPTURE   = 3'd2;
    localparam logic [2:0] c_DRAIN     = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;
    localparam logic [2:0] c_READ_REQ  = 3'd5;
    localparam logic [2:0] c_READ_WAIT = 3'd6;
    localparam logic [2:0] c_READ_HOLD = 3'd7;

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [c_CW-1:0]          r_wr_idx;
    logic [c_CW-1:0]          r_ack_cnt;
    logic [c_CW-1:0]          r_rd_idx;
    logic [index_bits-1:0]    r_waddr;
    logic                     r_wvalid;
    logic [i_bits+q_bits-1:0] r_wdata;
    logic [index_bits-1:0]    r_raddr;
    logic                     r_rvalid;
    logic                     r_rready;
    logic [i_bits-1:0]        r_out_i;
    logic [q_bits-1:0]        r_out_q;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic                     r_capture_done;
    logic                     r_overflow;
    logic                     r_busy;

    logic                     w_window;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_ack_inc;
    logic [c_CW-1:0]          w_wr_inc;
    logic [c_CW-1:0]          w_rd_inc;
    logic [c_CW-1:0]          w_ack_total;

    // Samples are taken on the trigger cycle in ARMED and on every cycle in CAPTURE.
    assign w_window    = ((r_state == c_ARMED) && trigger) || (r_state == c_CAPTURE);
    assign w_accept    = w_window && in_valid && s_axi_wready;
    assign w_drop      = w_window && in_valid && !s_axi_wready;
    assign w_wr_inc    = r_wr_idx + 1'b1;
    assign w_rd_inc    = r_rd_idx + 1'b1;
    // Acks only matter once writes can be outstanding; saturate at the buffer size.
    assign w_ack_inc   = ((r_state == c_CAPTURE) || (r_state == c_DRAIN)) &&
                         s_axi_bvalid && (r_ack_cnt != c_LEN);
    assign w_ack_total = w_ack_inc ? (r_ack_cnt + 1'b1) : r_ack_cnt;

    // Next-state selection for the capture/readout sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:      if (arm) w_state_next = c_ARMED;
            c_ARMED: begin
                if (w_accept && (w_wr_inc == c_LEN))
                    w_state_next = c_DRAIN;
                else if (trigger && in_valid)
                    w_state_next = c_CAPTURE;
            end
            c_CAPTURE:   if (w_accept && (w_wr_inc == c_LEN)) w_state_next = c_DRAIN;
            c_DRAIN:     if (w_ack_total == c_LEN) w_state_next = c_DONE;
            c_DONE: begin
                if (arm)
                    w_state_next = c_ARMED;
                else if (start_read)
                    w_state_next = c_READ_REQ;
            end
            c_READ_REQ:  w_state_next = c_READ_WAIT;
            c_READ_WAIT: if (s_axi_rvalid) w_state_next = c_READ_HOLD;
            c_READ_HOLD: if (out_ready) w_state_next = r_out_last ? c_DONE : c_READ_REQ;
            default:     w_state_next = c_IDLE;
        endcase
    end

    // State, counters and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_wr_idx       <= '0;
            r_ack_cnt      <= '0;
            r_rd_idx       <= '0;
            r_waddr        <= '0;
            r_wvalid       <= 1'b0;
            r_wdata        <= '0;
            r_raddr        <= '0;
            r_rvalid       <= 1'b0;
            r_rready       <= 1'b0;
            r_out_i        <= '0;
            r_out_q        <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_capture_done <= 1'b0;
            r_overflow     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next != c_IDLE) && (w_state_next != c_DONE);
            // Write and read strobes are single-cycle pulses by default.
            r_wvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rready <= 1'b0;

            if (w_accept) begin
                r_wvalid <= 1'b1;
                r_waddr  <= r_wr_idx[index_bits-1:0];
                r_wdata  <= {in_i, in_q};
                r_wr_idx <= w_wr_inc;
            end
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_ack_inc)
                r_ack_cnt <= w_ack_total;

            case (r_state)
                c_DRAIN: begin
                    if (w_state_next == c_DONE)
                        r_capture_done <= 1'b1;
                end
                c_DONE: begin
                    if (arm) begin
                        r_capture_done <= 1'b0;
                        r_overflow     <= 1'b0;
                        r_wr_idx       <= '0;
                        r_ack_cnt      <= '0;
                        r_rd_idx       <= '0;
                    end else if (start_read) begin
                        // Request is raised on entry so it is high during READ_REQ.
                        r_rd_idx <= '0;
                        r_raddr  <= '0;
                        r_rvalid <= 1'b1;
                        r_rready <= 1'b1;
                    end
                end
                c_READ_WAIT: begin
                    if (s_axi_rvalid) begin
                        r_out_i     <= s_i;
                        r_out_q     <= s_q;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_rd_idx == c_LAST);
                    end
                end
                c_READ_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (!r_out_last) begin
                            r_rd_idx <= w_rd_inc;
                            r_raddr  <= w_rd_inc[index_bits-1:0];
                            r_rvalid <= 1'b1;
                            r_rready <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_waddr  = r_waddr;
    assign m_axi_wvalid = r_wvalid;
    assign m_axi_wdata  = r_wdata;
    assign m_axi_raddr  = r_raddr;
    assign m_axi_rvalid = r_rvalid;
    assign m_axi_rready = r_rready;
    assign out_i        = r_out_i;
    assign out_q        = r_out_q;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign capture_done = r_capture_done;
    assign overflow     = r_overflow;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Self-checking bench for capture_sequencer with a buffer
//               model (1-cycle write ack, 2-cycle read latency) and
//               write/readout scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int LEN = 10;
    localparam int IB  = 4;
    localparam int WI  = 12;
    localparam int WQ  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0;
    logic trigger = 1'b0;
    logic in_valid = 1'b0;
    logic [WI-1:0] in_i = '0;
    logic [WQ-1:0] in_q = '0;
    logic start_read = 1'b0;
    logic s_axi_wready = 1'b1;
    logic s_axi_bvalid = 1'b0;
    logic s_axi_rvalid = 1'b0;
    logic [WI-1:0] s_i = '0;
    logic [WQ-1:0] s_q = '0;
    logic out_ready = 1'b0;

    logic [IB-1:0]    m_axi_waddr;
    logic             m_axi_wvalid;
    logic [WI+WQ-1:0] m_axi_wdata;
    logic [IB-1:0]    m_axi_raddr;
    logic             m_axi_rvalid;
    logic             m_axi_rready;
    logic [WI-1:0]    out_i;
    logic [WQ-1:0]    out_q;
    logic             out_valid;
    logic             out_last;
    logic             capture_done;
    logic             overflow;
    logic             busy;

    capture_sequencer #(
        .buffer_length(LEN), .index_bits(IB), .i_bits(WI), .q_bits(WQ)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .trigger(trigger),
        .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .start_read(start_read),
        .m_axi_waddr(m_axi_waddr), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wdata(m_axi_wdata), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .m_axi_raddr(m_axi_raddr),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .s_axi_rvalid(s_axi_rvalid), .s_i(s_i), .s_q(s_q),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .capture_done(capture_done), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WI-1:0] i;
        logic [WQ-1:0] q;
        logic          wready;
        logic          wr;
    } vec_t;

    typedef struct {
        logic [IB-1:0]    addr;
        logic [WI+WQ-1:0] data;
    } wr_t;

    typedef struct {
        logic [WI-1:0] i;
        logic [WQ-1:0] q;
        logic          last;
    } rd_t;

    vec_t vec [0:20];
    wr_t  wq [$];
    rd_t  rq [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_seen = 0;
    int hs_seen = 0;
    int rv_cyc = 0;
    int last_hs = 0;
    bit have_prev = 0;
    bit timing_chk = 0;
    logic [IB-1:0] exp_addr = '0;

    logic [WI+WQ-1:0] mem [0:(1<<IB)-1];
    logic b_d0 = 1'b0;
    logic r_d0 = 1'b0;
    logic r_d1 = 1'b0;
    logic [IB-1:0] a_d0 = '0;
    logic [IB-1:0] a_d1 = '0;
    logic prev_rv = 1'b0;
    logic prev_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: ack one cycle after each write, read data two cycles after request.
    always @(negedge clk) begin
        s_axi_bvalid = b_d0;
        b_d0 = m_axi_wvalid;
        if (m_axi_wvalid) mem[m_axi_waddr] = m_axi_wdata;
        s_axi_rvalid = r_d1;
        {s_i, s_q} = mem[a_d1];
        r_d1 = r_d0;
        a_d1 = a_d0;
        r_d0 = m_axi_rvalid;
        a_d0 = m_axi_raddr;
    end

    // Scoreboard monitor for the write bus, read requests and readout port.
    always @(negedge clk) begin
        wr_t e;
        rd_t r;
        if (m_axi_wvalid) begin
            wr_seen++;
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got addr=%0d expected none", m_axi_waddr);
            end else begin
                e = wq.pop_front();
                check("waddr", 32'(m_axi_waddr), 32'(e.addr));
                check("wdata", 32'(m_axi_wdata), 32'(e.data));
            end
            check("waddr_range", 32'(m_axi_waddr < IB'(LEN)), 32'd1);
        end
        if (m_axi_rvalid) begin
            check("rvalid_one_cycle", 32'(prev_rv), 32'd0);
            check("rready", 32'(m_axi_rready), 32'd1);
            check("raddr_range", 32'(m_axi_raddr < IB'(LEN)), 32'd1);
            rv_cyc = cyc;
        end
        if (out_valid && !prev_ov && timing_chk)
            check("read_latency", 32'(cyc - rv_cyc), 32'd3);
        if (out_valid && out_ready) begin
            hs_seen++;
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_readout got out_i=%0d expected none", out_i);
            end else begin
                r = rq.pop_front();
                check("out_i", 32'(out_i), 32'(r.i));
                check("out_q", 32'(out_q), 32'(r.q));
                check("out_last", 32'(out_last), 32'(r.last));
            end
            if (timing_chk && have_prev)
                check("read_spacing", 32'(cyc - last_hs), 32'd4);
            have_prev = 1;
            last_hs = cyc;
        end
        prev_rv = m_axi_rvalid;
        prev_ov = out_valid;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_capture_done"}, 32'(capture_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_wvalid"}, 32'(m_axi_wvalid), 32'd0);
        check({tag, "_waddr"}, 32'(m_axi_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(m_axi_wdata), 32'd0);
        check({tag, "_rvalid"}, 32'(m_axi_rvalid), 32'd0);
        check({tag, "_rready"}, 32'(m_axi_rready), 32'd0);
        check({tag, "_raddr"}, 32'(m_axi_raddr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_i"}, 32'(out_i), 32'd0);
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    task automatic pulse_start_read();
        @(posedge clk); #1 start_read = 1'b1;
        @(posedge clk); #1 start_read = 1'b0;
    endtask

    task automatic run_capture(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            @(posedge clk); #1;
            in_valid     = 1'b1;
            trigger      = (r == first);
            in_i         = vec[r].i;
            in_q         = vec[r].q;
            s_axi_wready = vec[r].wready;
            if (vec[r].wr) begin
                wq.push_back('{exp_addr, {vec[r].i, vec[r].q}});
                exp_addr++;
            end
        end
        @(posedge clk); #1;
        in_valid     = 1'b0;
        trigger      = 1'b0;
        s_axi_wready = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!capture_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_capture_done"}, 32'(capture_done), 32'd1);
        check({name, "_busy_after_done"}, 32'(busy), 32'd0);
        check({name, "_writes_pending"}, 32'(wq.size()), 32'd0);
    endtask

    task automatic wait_readout(input string name);
        int n = 0;
        while (rq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_readout_pending"}, 32'(rq.size()), 32'd0);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_out_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic push_readout();
        for (int k = 0; k < LEN; k++)
            rq.push_back('{vec[k].i, vec[k].q, (k == LEN - 1)});
    endtask

    initial begin
        // Rows 0..9: clean capture; rows 10..20: second sample stalled by wready=0.
        for (int k = 0; k < LEN; k++)
            vec[k] = '{WI'(k), WQ'(-k), 1'b1, 1'b1};
        for (int k = 0; k <= LEN; k++)
            vec[LEN + k] = '{WI'(k), WQ'(-k), (k != 1), (k != 1)};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // start_read in IDLE must do nothing.
        pulse_start_read();
        @(negedge clk);
        check("idle_start_read_busy", 32'(busy), 32'd0);
        check("idle_start_read_rvalid", 32'(m_axi_rvalid), 32'd0);

        pulse_arm();
        @(negedge clk);
        check("armed_busy", 32'(busy), 32'd1);

        // Trigger without a valid sample must not start a capture.
        @(posedge clk); #1 trigger = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("trigger_no_valid_wvalid", 32'(m_axi_wvalid), 32'd0);
        end
        @(posedge clk); #1 trigger = 1'b0;

        // Full capture.
        exp_addr = '0;
        wr_seen = 0;
        run_capture(0, LEN - 1);
        wait_done("full");
        check("full_overflow", 32'(overflow), 32'd0);
        check("full_write_count", 32'(wr_seen), 32'(LEN));

        // Readout with consumer always ready.
        out_ready = 1'b1;
        have_prev = 0;
        timing_chk = 1;
        hs_seen = 0;
        push_readout();
        pulse_start_read();
        wait_readout("read");
        repeat (2) @(negedge clk);
        timing_chk = 0;
        check("read_count", 32'(hs_seen), 32'(LEN));
        check("read_end_busy", 32'(busy), 32'd0);
        check("read_end_capture_done", 32'(capture_done), 32'd1);
        check("read_end_out_valid", 32'(out_valid), 32'd0);

        // Readout with backpressure held on sample 3.
        out_ready = 1'b0;
        push_readout();
        pulse_start_read();
        for (int k = 0; k < LEN; k++) begin
            wait_out_valid("bp");
            if (k == 3) begin
                for (int c = 0; c < 5; c++) begin
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    check("bp_hold_out_i", 32'(out_i), 32'(vec[3].i));
                    check("bp_hold_no_rvalid", 32'(m_axi_rvalid), 32'd0);
                    @(negedge clk);
                end
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
        @(negedge clk);
        check("bp_readout_pending", 32'(rq.size()), 32'd0);
        check("bp_end_busy", 32'(busy), 32'd0);
        check("bp_end_capture_done", 32'(capture_done), 32'd1);

        // Re-arm from DONE, then capture with the second sample dropped.
        pulse_arm();
        @(negedge clk);
        check("rearm_capture_done", 32'(capture_done), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
        exp_addr = '0;
        wr_seen = 0;
        run_capture(LEN, 2 * LEN);
        wait_done("drop");
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_write_count", 32'(wr_seen), 32'(LEN));

        // Re-arm clears the sticky overflow.
        pulse_arm();
        @(negedge clk);
        check("rearm_overflow_cleared", 32'(overflow), 32'd0);
        check("rearm2_capture_done", 32'(capture_done), 32'd0);

        // Reset in the middle of a capture, then restart from address 0.
        exp_addr = '0;
        run_capture(0, 3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        check("midrst_writes_pending", 32'(wq.size()), 32'd0);
        pulse_arm();
        exp_addr = '0;
        wr_seen = 0;
        run_capture(0, LEN - 1);
        wait_done("restart");
        check("restart_write_count", 32'(wr_seen), 32'(LEN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
